hazard_fwd_ctrl: RTL and testbench
==================================

Name: hazard_fwd_ctrl

Overview:
Pipeline hazard and forwarding controller for the five-stage core. It tracks the destination register of every in-flight instruction in EX, MEM and WB. From that it drives the execute stage's forwarding selects (ex_fwd_Rs/Rt, mem_fwd_Rs/Rt), the load-use stall and bubble, and the control-transfer flush. It sits beside decode, takes decode fields plus take_new_PC from execute, and feeds the IF/ID and ID/EX pipeline-register enables.

Parameters:
REG_BITS, 3, register-specifier width (8 GPRs, all writable, none hardwired)
FWD_EN, 1, 1 = forward from EX/MEM and MEM/WB; 0 = stall on any RAW hazard until the producer reaches WB
CNT_W, 16, width of the saturating performance counters

Ports:
clk  in  1  clock
rst_n  in  1  reset
id_valid  in  1  ID holds a real instruction
id_Rs  in  REG_BITS  source 1
id_Rt  in  REG_BITS  source 2
id_uses_Rs  in  1  instruction reads Rs
id_uses_Rt  in  1  instruction reads Rt
id_wr_en  in  1  instruction writes a register
id_wr_reg  in  REG_BITS  destination
id_is_load  in  1  instruction is LD
take_new_PC  in  1  branch/jump in EX redirects this cycle
mem_busy  in  1  data memory not ready; global freeze
stall_fd  out  1  hold PC and IF/ID
bubble_ex  out  1  load ID/EX with NOP
flush  out  1  squash IF/ID and ID/EX contents
ex_fwd_Rs  out  1  EX operand 1 from EX/MEM ALU result
ex_fwd_Rt  out  1  EX operand 2 from EX/MEM ALU result
mem_fwd_Rs  out  1  EX operand 1 from MEM/WB writeback value
mem_fwd_Rt  out  1  EX operand 2 from MEM/WB writeback value
stall_count  out  CNT_W  saturating count of hazard-stall cycles
flush_count  out  CNT_W  saturating count of flushes

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: all scoreboard entries invalid; all forwarding outputs 0; both counters 0. stall_fd, bubble_ex and flush are combinational and evaluate to 0 after reset.
- Scoreboard: three entries (EX, MEM, WB), each {valid, wr_en, reg, is_load}. The entries shift on each non-frozen clock: ID→EX, EX→MEM, MEM→WB. The EX entry loads invalid when bubble_ex or flush is asserted.
- Producer match: stage entry valid & wr_en & reg == source & the corresponding id_uses_*.
- Hazard, FWD_EN=1: hazard = id_valid & match on the EX entry & EX.is_load (load-use).
- Hazard, FWD_EN=0: hazard = id_valid & match on the EX or MEM entry. The register file writes before it reads, so WB needs no stall.
- Stall: when hazard & ~flush, assert stall_fd=1 and bubble_ex=1 in the same cycle.
- Forwarding next-state (FWD_EN=1 only; otherwise held 0). Computed for the ID instruction and registered on the ID→EX advance, so the outputs are valid while that instruction is in EX:
  - ex_fwd_X <= match on the EX entry & ~EX.is_load
  - mem_fwd_X <= match on the MEM entry & ~(match on the EX entry)
  - The youngest producer wins. ex_fwd and mem_fwd are never both 1.
- On bubble_ex or flush, the forwarding registers load 0.
- Flush: flush = take_new_PC. It overrides a hazard: stall_fd=0 and bubble_ex=0 that cycle, the ID instruction is discarded, and the EX entry loads invalid. The redirecting instruction itself moves on to MEM normally.
- Freeze: when mem_busy=1, all registers hold, stall_fd=1, bubble_ex=0, and flush passes through unchanged. Execute holds take_new_PC stable during a freeze.
- Counters: stall_count increments on each non-frozen cycle with bubble_ex=1. flush_count increments on each non-frozen cycle with flush=1. Both saturate at all-ones and never wrap.
- Reset mid-operation: everything clears immediately, with no pending stall or forward.

Decomposition:
- Shared package/include: REG_BITS default, the scoreboard entry field layout, and FWD_EN/CNT_W defaults.
- One natural sub-module: sat_counter (CNT_W-wide, inc enable, async active-low clear), instantiated twice.
- Scoreboard and match logic stay inline.

Test Plan:
1. ADD r1←r2,r3 then SUB r4←r1,r5 back to back → next cycle ex_fwd_Rs=1, all other fwd outputs 0, no stall.
2. ADD r1 then NOP then XOR r6←r7,r1 → XOR in EX sees mem_fwd_Rt=1, ex_fwd_Rt=0.
3. LD r2 then ADD r3←r2,r2 → one cycle of stall_fd=1 and bubble_ex=1, stall_count=1. ADD then enters EX with mem_fwd_Rs=mem_fwd_Rt=1.
4. LD r2 in EX with take_new_PC=1 while ID reads r2 → flush=1, bubble_ex=0, stall_fd=0, flush_count=1, EX entry invalid next cycle.
5. mem_busy=1 for 3 cycles during the case-3 stall → scoreboard and counters unchanged. The stall completes after mem_busy falls, with stall_count=1.
6. FWD_EN=0, ADD r1 then SUB using r1 → two stall cycles, all fwd outputs 0. Separately, force stall_count to 16'hFFFF and stall again → stays 16'hFFFF.

Source files
------------

// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared defaults and scoreboard entry layout for the hazard/forwarding controller.
package hazard_fwd_ctrl_pkg;

    localparam int REG_BITS_DEF = 3;
    localparam bit FWD_EN_DEF   = 1'b1;
    localparam int CNT_W_DEF    = 16;

    // Entry field order {valid, wr_en, reg, is_load}; the top re-declares it at its own REG_BITS.
    typedef struct packed {
        logic                    valid;
        logic                    wr_en;
        logic [REG_BITS_DEF-1:0] rd;
        logic                    is_load;
    } sb_entry_t;

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Decode/execute side of the hazard controller: ID fields, redirect/freeze in, stalls/selects out.
interface hazard_fwd_ctrl_if
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int REG_BITS = REG_BITS_DEF,
    parameter int CNT_W    = CNT_W_DEF
);
    logic                      id_valid;
    logic [REG_BITS-1:0]       id_Rs;
    logic [REG_BITS-1:0]       id_Rt;
    logic                      id_uses_Rs;
    logic                      id_uses_Rt;
    logic                      id_wr_en;
    logic [REG_BITS-1:0]       id_wr_reg;
    logic                      id_is_load;
    logic                      take_new_PC;
    logic                      mem_busy;
    logic                      stall_fd;
    logic                      bubble_ex;
    logic                      flush;
    logic                      ex_fwd_Rs;
    logic                      ex_fwd_Rt;
    logic                      mem_fwd_Rs;
    logic                      mem_fwd_Rt;
    logic [CNT_W-1:0]          stall_count;
    logic [CNT_W-1:0]          flush_count;
    // Scoreboard snapshot {EX, MEM, WB}, each entry {valid, wr_en, reg, is_load}.
    logic [3*(REG_BITS+3)-1:0] sb_dbg;

    modport master (
        output id_valid, id_Rs, id_Rt, id_uses_Rs, id_uses_Rt, id_wr_en, id_wr_reg, id_is_load,
        output take_new_PC, mem_busy,
        input  stall_fd, bubble_ex, flush, ex_fwd_Rs, ex_fwd_Rt, mem_fwd_Rs, mem_fwd_Rt,
        input  stall_count, flush_count, sb_dbg
    );

    modport slave (
        input  id_valid, id_Rs, id_Rt, id_uses_Rs, id_uses_Rt, id_wr_en, id_wr_reg, id_is_load,
        input  take_new_PC, mem_busy,
        output stall_fd, bubble_ex, flush, ex_fwd_Rs, ex_fwd_Rt, mem_fwd_Rs, mem_fwd_Rt,
        output stall_count, flush_count, sb_dbg
    );

endinterface

// File: rtl/hazard_fwd_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module hazard_fwd_ctrl_sat_counter
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Five-stage pipeline hazard controller: tracks EX/MEM/WB destinations, drives
// forwarding selects, load-use stall/bubble and control-transfer flush.
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int REG_BITS = REG_BITS_DEF,
    parameter bit FWD_EN   = FWD_EN_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input logic              clk,
    input logic              rst_n,
    hazard_fwd_ctrl_if.slave bus
);

    typedef struct packed {
        logic                valid;
        logic                wr_en;
        logic [REG_BITS-1:0] rd;
        logic                is_load;
    } entry_t;

    entry_t     ex_q, mem_q, wb_q, id_entry;
    logic [3:0] fwd_q, fwd_nxt;  // {ex_Rs, ex_Rt, mem_Rs, mem_Rt}
    logic       m_ex_rs, m_ex_rt, m_mem_rs, m_mem_rt;
    logic       hazard, kill;

    assign id_entry = {bus.id_valid, bus.id_wr_en, bus.id_wr_reg, bus.id_is_load};

    always_comb begin
        m_ex_rs  = ex_q.valid  & ex_q.wr_en  & (ex_q.rd  == bus.id_Rs) & bus.id_uses_Rs;
        m_ex_rt  = ex_q.valid  & ex_q.wr_en  & (ex_q.rd  == bus.id_Rt) & bus.id_uses_Rt;
        m_mem_rs = mem_q.valid & mem_q.wr_en & (mem_q.rd == bus.id_Rs) & bus.id_uses_Rs;
        m_mem_rt = mem_q.valid & mem_q.wr_en & (mem_q.rd == bus.id_Rt) & bus.id_uses_Rt;
        // Without forwarding any in-flight producer ahead of WB blocks; with it only a load in EX does.
        hazard   = FWD_EN ? (bus.id_valid & (m_ex_rs | m_ex_rt) & ex_q.is_load)
                          : (bus.id_valid & (m_ex_rs | m_ex_rt | m_mem_rs | m_mem_rt));
        // Youngest producer wins, so a MEM match is ignored whenever EX also matches.
        fwd_nxt  = {FWD_EN & m_ex_rs & ~ex_q.is_load,
                    FWD_EN & m_ex_rt & ~ex_q.is_load,
                    FWD_EN & m_mem_rs & ~m_ex_rs,
                    FWD_EN & m_mem_rt & ~m_ex_rt};
    end

    assign bus.flush     = bus.take_new_PC;
    assign bus.stall_fd  = bus.mem_busy | (hazard & ~bus.take_new_PC);
    assign bus.bubble_ex = hazard & ~bus.take_new_PC & ~bus.mem_busy;
    assign kill          = bus.bubble_ex | bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            fwd_q <= '0;
        end else if (!bus.mem_busy) begin
            ex_q  <= kill ? entry_t'('0) : id_entry;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            fwd_q <= kill ? 4'b0000 : fwd_nxt;
        end
    end

    assign {bus.ex_fwd_Rs, bus.ex_fwd_Rt, bus.mem_fwd_Rs, bus.mem_fwd_Rt} = fwd_q;
    assign bus.sb_dbg = {ex_q, mem_q, wb_q};

    hazard_fwd_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.bubble_ex),
        .count (bus.stall_count)
    );

    hazard_fwd_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.flush & ~bus.mem_busy),
        .count (bus.flush_count)
    );

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: a forwarding instance (16-bit counters) and a
// non-forwarding instance (4-bit counters) share one stimulus stream.
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_uses_Rs, id_uses_Rt, id_wr_en, id_is_load, take_new_PC, mem_busy;
    logic [2:0] id_Rs, id_Rt, id_wr_reg;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl_if #(.REG_BITS(3), .CNT_W(16)) bus0 ();
    hazard_fwd_ctrl_if #(.REG_BITS(3), .CNT_W(4))  bus1 ();

    assign bus0.id_valid = id_valid;     assign bus1.id_valid = id_valid;
    assign bus0.id_Rs = id_Rs;           assign bus1.id_Rs = id_Rs;
    assign bus0.id_Rt = id_Rt;           assign bus1.id_Rt = id_Rt;
    assign bus0.id_uses_Rs = id_uses_Rs; assign bus1.id_uses_Rs = id_uses_Rs;
    assign bus0.id_uses_Rt = id_uses_Rt; assign bus1.id_uses_Rt = id_uses_Rt;
    assign bus0.id_wr_en = id_wr_en;     assign bus1.id_wr_en = id_wr_en;
    assign bus0.id_wr_reg = id_wr_reg;   assign bus1.id_wr_reg = id_wr_reg;
    assign bus0.id_is_load = id_is_load; assign bus1.id_is_load = id_is_load;
    assign bus0.take_new_PC = take_new_PC; assign bus1.take_new_PC = take_new_PC;
    assign bus0.mem_busy = mem_busy;     assign bus1.mem_busy = mem_busy;

    hazard_fwd_ctrl #(.REG_BITS(3), .FWD_EN(1'b1), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    hazard_fwd_ctrl #(.REG_BITS(3), .FWD_EN(1'b0), .CNT_W(4))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Reference model: the instructions in flight, indexed by age (1 = in EX, 2 = in MEM).
    logic       m_v [2][1:2];
    logic       m_wr[2][1:2];
    logic       m_ld[2][1:2];
    logic [2:0] m_rd[2][1:2];
    logic [3:0] e_fwd[2];
    int         e_stall[2];
    int         e_flush[2];
    int         cmax[2] = '{65535, 15};

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int a = 1; a <= 2; a++) begin
                m_v[k][a] = 1'b0; m_wr[k][a] = 1'b0; m_ld[k][a] = 1'b0; m_rd[k][a] = 3'd0;
            end
            e_fwd[k] = 4'd0; e_stall[k] = 0; e_flush[k] = 0;
        end
    endtask

    // Age of the youngest in-flight writer of src, 0 if none is ahead of WB.
    function automatic int youngest(int k, logic [2:0] src);
        int age = 0;
        for (int a = 2; a >= 1; a--)
            if (m_v[k][a] && m_wr[k][a] && (m_rd[k][a] == src)) age = a;
        return age;
    endfunction

    task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    // Called 1 time unit after a rising edge with inputs applied; checks, advances the model, waits a cycle.
    task automatic step(string tag);
        #2;
        for (int k = 0; k < 2; k++) begin
            int         drs, drt;
            logic       haz, st, bub, kill;
            logic [3:0] nxt;
            logic [3:0] obs_fwd;
            logic [17:0] obs_sb;
            drs = id_uses_Rs ? youngest(k, id_Rs) : 0;
            drt = id_uses_Rt ? youngest(k, id_Rt) : 0;
            if (k == 0) haz = id_valid && ((drs == 1) || (drt == 1)) && m_ld[k][1];
            else        haz = id_valid && ((drs != 0) || (drt != 0));
            st  = mem_busy | (haz & ~take_new_PC);
            bub = haz & ~take_new_PC & ~mem_busy;
            nxt = (k == 0) ? {(drs == 1) & ~m_ld[k][1], (drt == 1) & ~m_ld[k][1], drs == 2, drt == 2} : 4'd0;
            obs_fwd = (k == 0) ? {bus0.ex_fwd_Rs, bus0.ex_fwd_Rt, bus0.mem_fwd_Rs, bus0.mem_fwd_Rt}
                               : {bus1.ex_fwd_Rs, bus1.ex_fwd_Rt, bus1.mem_fwd_Rs, bus1.mem_fwd_Rt};
            obs_sb  = (k == 0) ? bus0.sb_dbg : bus1.sb_dbg;
            chk({tag, ".stall_fd"},  k, 32'((k == 0) ? bus0.stall_fd  : bus1.stall_fd),  32'(st));
            chk({tag, ".bubble_ex"}, k, 32'((k == 0) ? bus0.bubble_ex : bus1.bubble_ex), 32'(bub));
            chk({tag, ".flush"},     k, 32'((k == 0) ? bus0.flush     : bus1.flush),     32'(take_new_PC));
            chk({tag, ".fwd"},       k, 32'(obs_fwd), 32'(e_fwd[k]));
            chk({tag, ".stall_count"}, k, (k == 0) ? 32'(bus0.stall_count) : 32'(bus1.stall_count), e_stall[k]);
            chk({tag, ".flush_count"}, k, (k == 0) ? 32'(bus0.flush_count) : 32'(bus1.flush_count), e_flush[k]);
            chk({tag, ".ex_valid"},  k, 32'(obs_sb[17]), 32'(m_v[k][1]));
            chk({tag, ".mem_valid"}, k, 32'(obs_sb[11]), 32'(m_v[k][2]));
            if (rst_n && !mem_busy) begin
                kill = bub | take_new_PC;
                m_v[k][2] = m_v[k][1]; m_wr[k][2] = m_wr[k][1]; m_ld[k][2] = m_ld[k][1]; m_rd[k][2] = m_rd[k][1];
                m_v[k][1]  = kill ? 1'b0 : id_valid;
                m_wr[k][1] = kill ? 1'b0 : id_wr_en;
                m_ld[k][1] = kill ? 1'b0 : id_is_load;
                m_rd[k][1] = kill ? 3'd0 : id_wr_reg;
                e_fwd[k]   = kill ? 4'd0 : nxt;
                if (bub && e_stall[k] < cmax[k]) e_stall[k]++;
                if (take_new_PC && e_flush[k] < cmax[k]) e_flush[k]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic instr(logic v, logic [2:0] rd, logic [2:0] rs, logic [2:0] rt,
                         logic urs, logic urt, logic wr, logic ld);
        id_valid = v; id_wr_reg = rd; id_Rs = rs; id_Rt = rt;
        id_uses_Rs = urs; id_uses_Rt = urt; id_wr_en = wr; id_is_load = ld;
    endtask

    task automatic nop();
        instr(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        nop(); take_new_PC = 1'b0; mem_busy = 1'b0;
        model_clear();
        step("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Back-to-back dependence: SUB takes r1 from EX/MEM.
        instr(1, 3'd1, 3'd2, 3'd3, 1, 1, 1, 0); step("add_sub.add");
        instr(1, 3'd4, 3'd1, 3'd5, 1, 1, 1, 0); step("add_sub.sub");
        nop(); step("add_sub.ex"); step("add_sub.drain");

        // One-instruction gap: XOR takes r1 from MEM/WB on Rt.
        instr(1, 3'd1, 3'd2, 3'd3, 1, 1, 1, 0); step("gap.add");
        nop(); step("gap.nop");
        instr(1, 3'd6, 3'd7, 3'd1, 1, 1, 1, 0); step("gap.xor");
        nop(); step("gap.ex"); step("gap.drain");

        // Load-use: one bubble, then MEM/WB forwarding on both operands.
        instr(1, 3'd2, 3'd0, 3'd0, 1, 0, 1, 1); step("ldu.ld");
        instr(1, 3'd3, 3'd2, 3'd2, 1, 1, 1, 0); step("ldu.stall"); step("ldu.go");
        nop(); step("ldu.ex"); step("ldu.drain");

        // Redirect while a load-use hazard is pending: flush wins.
        instr(1, 3'd2, 3'd0, 3'd0, 1, 0, 1, 1); step("fl.ld");
        instr(1, 3'd3, 3'd2, 3'd2, 1, 1, 1, 0); take_new_PC = 1'b1; step("fl.flush");
        take_new_PC = 1'b0; nop(); step("fl.after"); step("fl.drain");

        // Freeze during a load-use stall.
        instr(1, 3'd2, 3'd0, 3'd0, 1, 0, 1, 1); step("frz.ld");
        instr(1, 3'd3, 3'd2, 3'd2, 1, 1, 1, 0); mem_busy = 1'b1;
        step("frz.b0"); step("frz.b1"); step("frz.b2");
        mem_busy = 1'b0; step("frz.stall"); step("frz.go");
        nop(); step("frz.ex"); step("frz.drain");

        // Repeated RAW pairs push the narrow non-forwarding stall counter into saturation.
        for (int i = 0; i < 10; i++) begin
            instr(1, 3'd1, 3'd2, 3'd3, 1, 1, 1, 0); step("sat.add");
            instr(1, 3'd4, 3'd1, 3'd5, 1, 1, 1, 0); step("sat.sub0"); step("sat.sub1"); step("sat.sub2");
        end
        nop(); step("sat.drain");
        chk("sat.stall_count_pinned", 1, 32'(bus1.stall_count), 32'hF);

        // Randomized traffic with a reset dropped in mid-stream.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            instr(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                  3'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) == 0));
            take_new_PC = ($urandom_range(0, 7) == 0);
            mem_busy    = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
